// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data memory port: one request at a time, aligned accesses in one beat,
// misaligned halfword/word accesses split into byte beats and reassembled.
module lsu_mem_master #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [3:0]            mem_addr_mode,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_LBU = 4'b0011;
   localparam logic [3:0] OP_LHU = 4'b0100;
   localparam logic [3:0] OP_SB  = 4'b0101;
   localparam logic [3:0] OP_SH  = 4'b0110;
   localparam logic [3:0] OP_SW  = 4'b0111;

   state_t                state_q, state_d;
   logic [3:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  split_q;
   logic [1:0]            last_q;
   logic [1:0]            beat_q;
   logic [DATA_WIDTH-1:0] asm_q, asm_next;
   logic [DATA_WIDTH-1:0] rdata_q, ext_rdata;
   logic                  err_q;

   logic req_illegal, req_misaligned, req_reject, is_store, last_beat;

   // Request classification is done on the live request so the first beat can follow acceptance directly.
   assign req_illegal    = req_op[3];
   assign req_misaligned = ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0]) ||
                           ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00));
   assign req_reject     = req_illegal || (req_misaligned && (SPLIT_MISALIGNED == 0));

   assign is_store  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
   assign last_beat = !split_q || (beat_q == last_q);

   assign req_ready  = (state_q == IDLE) && !rst;
   assign resp_valid = (state_q == RESP) && !rst;
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid && err_q;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d       = state_q;
      mem_addr_mode = OP_LW;
      mem_addr      = '0;
      mem_wdata     = '0;
      asm_next      = asm_q;
      asm_next[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];

      case (op_q)
         OP_LH:   ext_rdata = {{(DATA_WIDTH-16){asm_next[15]}}, asm_next[15:0]};
         OP_LHU:  ext_rdata = {{(DATA_WIDTH-16){1'b0}}, asm_next[15:0]};
         default: ext_rdata = asm_next;
      endcase

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready)
               state_d = req_reject ? RESP : BEAT;
         end
         BEAT: begin
            // Outputs drop to the non-store default under reset so an aborted split store writes nothing more.
            if (!rst) begin
               if (split_q) begin
                  mem_addr_mode = is_store ? OP_SB : OP_LBU;
                  mem_addr      = addr_q + ADDR_WIDTH'(beat_q);
                  if (is_store)
                     mem_wdata[7:0] = wdata_q[{beat_q, 3'b000} +: 8];
               end else begin
                  mem_addr_mode = op_q;
                  mem_addr      = addr_q;
                  mem_wdata     = wdata_q;
               end
            end
            if (last_beat)
               state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_LW;
         addr_q  <= '0;
         wdata_q <= '0;
         split_q <= 1'b0;
         last_q  <= 2'd0;
         beat_q  <= 2'd0;
         asm_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  split_q <= req_misaligned;
                  last_q  <= (req_op == OP_LW || req_op == OP_SW) ? 2'd3 : 2'd1;
                  beat_q  <= 2'd0;
                  asm_q   <= '0;
                  rdata_q <= '0;
                  err_q   <= req_reject;
               end
            end
            BEAT: begin
               if (split_q) begin
                  asm_q  <= asm_next;
                  beat_q <= beat_q + 2'd1;
                  if (last_beat && !is_store)
                     rdata_q <= ext_rdata;
               end else if (!is_store) begin
                  rdata_q <= mem_rdata;
               end
            end
            default: begin
               beat_q <= 2'd0;
               err_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: byte-addressed memory model on the splitting instance, plus a
// non-splitting instance sharing the request inputs for the reject path.
module tb_lsu_mem_master;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [3:0]  mem_addr_mode;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        ns_req_ready, ns_resp_valid, ns_resp_err;
   logic [31:0] ns_resp_rdata;
   logic [3:0]  ns_mem_addr_mode;
   logic [31:0] ns_mem_addr, ns_mem_wdata;
   logic [31:0] ns_mem_rdata;

   int total = 0;
   int bad   = 0;

   lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(0)) dut_ns (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(ns_req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
      .mem_addr_mode(ns_mem_addr_mode), .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
      .mem_rdata(ns_mem_rdata)
   );

   assign ns_mem_rdata = 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: 4 KiB aliased by addr[11:0], AddrMode semantics for reads and writes.
   logic [7:0]  mem [0:4095];
   logic [11:0] m_a;
   logic [7:0]  m_b0, m_b1, m_b2, m_b3;
   logic        pl_en;
   logic [11:0] pl_addr;
   logic [7:0]  pl_data;

   always_comb begin
      m_a  = mem_addr[11:0];
      m_b0 = mem[m_a];
      m_b1 = mem[12'(m_a + 12'd1)];
      m_b2 = mem[12'(m_a + 12'd2)];
      m_b3 = mem[12'(m_a + 12'd3)];
      case (mem_addr_mode)
         4'b0000: mem_rdata = {{24{m_b0[7]}}, m_b0};
         4'b0001: mem_rdata = {{16{m_b1[7]}}, m_b1, m_b0};
         4'b0010: mem_rdata = {m_b3, m_b2, m_b1, m_b0};
         4'b0011: mem_rdata = {24'd0, m_b0};
         4'b0100: mem_rdata = {16'd0, m_b1, m_b0};
         default: mem_rdata = 32'd0;
      endcase
   end

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else begin
         case (mem_addr_mode)
            4'b0101: mem[m_a] <= mem_wdata[7:0];
            4'b0110: begin
               mem[m_a]              <= mem_wdata[7:0];
               mem[12'(m_a + 12'd1)] <= mem_wdata[15:8];
            end
            4'b0111: begin
               mem[m_a]              <= mem_wdata[7:0];
               mem[12'(m_a + 12'd1)] <= mem_wdata[15:8];
               mem[12'(m_a + 12'd2)] <= mem_wdata[23:16];
               mem[12'(m_a + 12'd3)] <= mem_wdata[31:24];
            end
            default: ;
         endcase
      end
   end

   // Observation mux so one request task serves both instances.
   logic        sel_ns;
   logic        o_ready, o_rvalid, o_err;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_mode;

   always_comb begin
      if (sel_ns) begin
         o_ready = ns_req_ready;  o_rvalid = ns_resp_valid; o_err = ns_resp_err;
         o_rdata = ns_resp_rdata; o_mode = ns_mem_addr_mode;
         o_addr  = ns_mem_addr;   o_wdata = ns_mem_wdata;
      end else begin
         o_ready = req_ready;     o_rvalid = resp_valid;   o_err = resp_err;
         o_rdata = resp_rdata;    o_mode = mem_addr_mode;
         o_addr  = mem_addr;      o_wdata = mem_wdata;
      end
   end

   int          lat, nb;
   logic [31:0] rd;
   logic        er;
   logic [3:0]  bm_mode [8];
   logic [31:0] bm_addr [8];
   logic [31:0] bm_wd   [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic wait_both_ready(input string tag);
      int w = 0;
      while (!(req_ready && ns_req_ready) && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (w >= 10) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   // Issue one request, then record every non-idle memory cycle and the response cycle offset.
   task automatic run_req(input string tag, input logic ns, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] wd);
      logic quiet;
      sel_ns = ns;
      wait_both_ready(tag);
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_op = 4'b1111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
      lat = 0; nb = 0; rd = 32'd0; er = 1'b0; quiet = 1'b1;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (o_mode != 4'b0010 || o_addr != 32'd0 || o_wdata != 32'd0) begin
            if (nb < 8) begin
               bm_mode[nb] = o_mode; bm_addr[nb] = o_addr; bm_wd[nb] = o_wdata;
            end
            nb++;
         end
         if (o_ready) quiet = 1'b0;
         if (o_rvalid) begin
            lat = i; rd = o_rdata; er = o_err;
         end else if (o_rdata != 32'd0 || o_err) begin
            quiet = 1'b0;
         end
      end
      check({tag, "_lat"}, lat, (lat == 0) ? 32'hFFFF_FFFF : lat);
      check({tag, "_quiet"}, {31'd0, quiet}, 32'd1);
   endtask

   task automatic expect_resp(input string tag, input int e_lat, input logic [31:0] e_rd,
                              input logic e_err, input int e_nb);
      check({tag, "_latency"}, lat, e_lat);
      check({tag, "_rdata"}, rd, e_rd);
      check({tag, "_err"}, {31'd0, er}, {31'd0, e_err});
      check({tag, "_beats"}, nb, e_nb);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic resp_seen;
      rst = 1'b1; req_valid = 1'b0; req_op = 4'b0000; req_addr = 32'd0; req_wdata = 32'd0;
      pl_en = 1'b0; pl_addr = 12'd0; pl_data = 8'd0; sel_ns = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_mode", {28'd0, mem_addr_mode}, 32'h2);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Aligned LW
      preload(12'h100, 8'h78); preload(12'h101, 8'h56);
      preload(12'h102, 8'h34); preload(12'h103, 8'h12);
      run_req("lw_al", 1'b0, 4'b0010, 32'h100, 32'h0);
      expect_resp("lw_al", 2, 32'h1234_5678, 1'b0, 1);
      check("lw_al_mode", {28'd0, bm_mode[0]}, 32'h2);
      check("lw_al_addr", bm_addr[0], 32'h100);

      // Misaligned SW then split LW
      run_req("sw_sp", 1'b0, 4'b0111, 32'h201, 32'hAABB_CCDD);
      expect_resp("sw_sp", 5, 32'd0, 1'b0, 4);
      begin
         logic [31:0] exp_wd [4];
         exp_wd[0] = 32'hDD; exp_wd[1] = 32'hCC; exp_wd[2] = 32'hBB; exp_wd[3] = 32'hAA;
         for (int k = 0; k < 4; k++) begin
            check($sformatf("sw_sp_mode%0d", k), {28'd0, bm_mode[k]}, 32'h5);
            check($sformatf("sw_sp_addr%0d", k), bm_addr[k], 32'h201 + k);
            check($sformatf("sw_sp_wd%0d", k), bm_wd[k], exp_wd[k]);
         end
      end
      run_req("lw_sp", 1'b0, 4'b0010, 32'h201, 32'h0);
      expect_resp("lw_sp", 5, 32'hAABB_CCDD, 1'b0, 4);
      check("lw_sp_mode", {28'd0, bm_mode[3]}, 32'h3);
      check("lw_sp_addr3", bm_addr[3], 32'h204);

      // Misaligned LH / LHU extension
      preload(12'h301, 8'h34); preload(12'h302, 8'h80);
      run_req("lh_sp", 1'b0, 4'b0001, 32'h301, 32'h0);
      expect_resp("lh_sp", 3, 32'hFFFF_8034, 1'b0, 2);
      run_req("lhu_sp", 1'b0, 4'b0100, 32'h301, 32'h0);
      expect_resp("lhu_sp", 3, 32'h0000_8034, 1'b0, 2);

      // Aligned LB passes its own mode to the memory
      run_req("lb_al", 1'b0, 4'b0000, 32'h302, 32'h0);
      expect_resp("lb_al", 2, 32'hFFFF_FF80, 1'b0, 1);
      check("lb_al_mode", {28'd0, bm_mode[0]}, 32'h0);

      // Illegal op, and misaligned LW on the non-splitting instance
      run_req("illegal", 1'b0, 4'b1010, 32'h100, 32'h1234_5678);
      expect_resp("illegal", 1, 32'd0, 1'b1, 0);
      run_req("ns_lw", 1'b1, 4'b0010, 32'h102, 32'h0);
      expect_resp("ns_lw", 1, 32'd0, 1'b1, 0);
      sel_ns = 1'b0;

      // Address wrap on a split SH
      run_req("sh_wrap", 1'b0, 4'b0110, 32'hFFFF_FFFF, 32'h0000_1234);
      expect_resp("sh_wrap", 3, 32'd0, 1'b0, 2);
      check("sh_wrap_addr0", bm_addr[0], 32'hFFFF_FFFF);
      check("sh_wrap_wd0", bm_wd[0], 32'h34);
      check("sh_wrap_addr1", bm_addr[1], 32'h0000_0000);
      check("sh_wrap_wd1", bm_wd[1], 32'h12);
      check("sh_wrap_mem_fff", {24'd0, mem[12'hFFF]}, 32'h34);
      check("sh_wrap_mem_000", {24'd0, mem[12'h000]}, 32'h12);

      // Reset during beat 2 of a split SW
      preload(12'h401, 8'h11); preload(12'h402, 8'h22);
      preload(12'h403, 8'h33); preload(12'h404, 8'h44);
      wait_both_ready("rst_mid");
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'b0111; req_addr = 32'h401; req_wdata = 32'hA1B2_C3D4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_beat0_addr", mem_addr, 32'h401);
      @(negedge clk);
      check("rst_mid_beat1_wd", mem_wdata, 32'hC3);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_mid_mode_gated", {28'd0, mem_addr_mode}, 32'h2);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      resp_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) resp_seen = 1'b1;
      end
      check("rst_mid_no_resp", {31'd0, resp_seen}, 32'd0);
      check("rst_mid_mem401", {24'd0, mem[12'h401]}, 32'hD4);
      check("rst_mid_mem402", {24'd0, mem[12'h402]}, 32'hC3);
      check("rst_mid_mem403", {24'd0, mem[12'h403]}, 32'h33);
      check("rst_mid_mem404", {24'd0, mem[12'h404]}, 32'h44);

      // Normal operation resumes after the abort
      run_req("lw_after", 1'b0, 4'b0010, 32'h100, 32'h0);
      expect_resp("lw_after", 2, 32'h1234_5678, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
